// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush scheduler for the five-stage pipeline.
// Resolves load-use, taken-branch, multi-cycle MDU and data-memory wait
// hazards, with a watchdog that bounds every wait state.
// Optional build macro: HAZARD_PERF_EN adds stall/flush performance counters;
// without it both counter ports are tied to zero and no counter flops exist.
module hazard_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        d_uses_rs1,
  input  logic        d_uses_rs2,
  input  logic [4:0]  e_rd,
  input  logic        e_is_load,
  input  logic        e_branch_taken,
  input  logic        e_mdu_start,
  input  logic        mdu_done,
  input  logic        m_mem_req,
  input  logic        m_mem_ready,
  output logic        pc_enable,
  output logic        fd_enable,
  output logic        de_enable,
  output logic        em_enable,
  output logic        mw_enable,
  output logic        fd_flush,
  output logic        de_flush,
  output logic        em_flush,
  output logic        hazard_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WCNT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  state_e          mode;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            err_q, err_d;
  logic            ms, lu, expire;
  logic            mdu_hold, redirect, bubble;

  assign ms = m_mem_req & ~m_mem_ready;
  assign lu = e_is_load & (e_rd != 5'd0) &
              ((d_uses_rs1 & (d_rs1 == e_rd)) | (d_uses_rs2 & (d_rs2 == e_rd)));

  // The watchdog only fires from a wait state once the counter hits its limit.
  assign expire = (TIMEOUT > 0) && (state_q != RUN) && (wcnt_q == WCNT_LAST);

  // Effective mode: the cycle a memory wait ends behaves like the saved state.
  always_comb begin
    mode = state_q;
    if (state_q == MEM_WAIT && !ms) mode = ret_q;
  end

  // Classify this cycle's hazard by priority: ms > MDU > branch > load-use.
  always_comb begin
    mdu_hold = 1'b0;
    redirect = 1'b0;
    bubble   = 1'b0;
    if (!ms) begin
      if (mode == MDU_WAIT) begin
        mdu_hold = ~mdu_done;
      end else if (e_mdu_start) begin
        mdu_hold = 1'b1;
      end else if (e_branch_taken) begin
        redirect = 1'b1;
      end else if (lu) begin
        bubble = 1'b1;
      end
    end
  end

  // Register enables and flushes derived from the classified hazard.
  always_comb begin
    pc_enable = ~ms & ~mdu_hold & ~bubble;
    fd_enable = ~ms & ~mdu_hold & ~bubble;
    de_enable = ~ms & ~mdu_hold;
    em_enable = ~ms;
    mw_enable = ~ms;
    fd_flush  = redirect;
    de_flush  = redirect | bubble;
    em_flush  = mdu_hold;
  end

  // Next state, return state, wait counter and sticky error.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    err_d   = err_q;
    if (ms) begin
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) ret_d = state_q;
    end else if (mode == MDU_WAIT) begin
      state_d = mdu_done ? RUN : MDU_WAIT;
    end else begin
      state_d = e_mdu_start ? MDU_WAIT : RUN;
    end
    if (expire) begin
      state_d = RUN;
      ret_d   = RUN;
      err_d   = 1'b1;
    end
    // Any entry into a wait state (including MDU<->MEM hops) restarts the count.
    wcnt_d = (state_d != RUN && state_d == state_q) ? wcnt_q + 1'b1 : '0;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign hazard_err = err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q;

  // Free-running counters of stalled and flushing cycles; wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_enable) stall_q <= stall_q + 32'd1;
      if (fd_flush | de_flush | em_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: reset checks, a vector table of single-cycle hazard
// cases, hand sequences for MDU/memory/watchdog/reset corners, and random
// traffic compared against a rule-level model of the scheduler.
module tb_hazard_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] d_rs1, d_rs2, e_rd;
  logic d_uses_rs1, d_uses_rs2, e_is_load, e_branch_taken, e_mdu_start;
  logic mdu_done, m_mem_req, m_mem_ready;
  logic pc_enable, fd_enable, de_enable, em_enable, mw_enable;
  logic fd_flush, de_flush, em_flush, hazard_err;
  logic [31:0] stall_cycles, flush_events;

  hazard_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .e_rd(e_rd), .e_is_load(e_is_load), .e_branch_taken(e_branch_taken),
    .e_mdu_start(e_mdu_start), .mdu_done(mdu_done),
    .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
    .pc_enable(pc_enable), .fd_enable(fd_enable), .de_enable(de_enable),
    .em_enable(em_enable), .mw_enable(mw_enable),
    .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush),
    .hazard_err(hazard_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld; logic [4:0] rd; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic br; logic st; logic dn; logic rq; logic rdy;
  } in_t;

  typedef struct { in_t i; logic [7:0] exp; string name; } vec_t;

  // Output vector order: {pc, fd, de, em, mw, fd_flush, de_flush, em_flush}
  localparam logic [7:0] O_DEF   = 8'b11111_000;
  localparam logic [7:0] O_LU    = 8'b00111_010;
  localparam logic [7:0] O_BR    = 8'b11111_110;
  localparam logic [7:0] O_MDU   = 8'b00011_001;
  localparam logic [7:0] O_FREEZE = 8'b00000_000;

  int n_cmp = 0;
  int n_bad = 0;

  // Rule-level model: 0 = running, 1 = waiting on MDU, 2 = waiting on memory.
  int m_state, m_ret, m_wait;
  logic m_err;
  logic [31:0] m_stall, m_flush;
  logic [7:0] exp_o, last_o;
  int n_state, n_ret;
  bit n_exp;

  function automatic in_t mkin(logic ld, logic [4:0] rd, logic [4:0] rs1, logic u1,
                               logic [4:0] rs2, logic u2, logic br, logic st,
                               logic dn, logic rq, logic rdy);
    in_t v;
    v.ld = ld; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.br = br; v.st = st; v.dn = dn; v.rq = rq; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic mdl_reset();
    m_state = 0; m_ret = 0; m_wait = 0; m_err = 1'b0;
    m_stall = '0; m_flush = '0;
  endtask

  // Work out what the pipeline must do this cycle and where it goes next.
  task automatic mdl_eval(input in_t v);
    bit mem_stall, dep, run_like, mdu_like, hold, redir, bub;
    mem_stall = v.rq && !v.rdy;
    dep = v.ld && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    mdu_like = (m_state == 1) || (m_state == 2 && m_ret == 1);
    run_like = !mdu_like;
    hold  = !mem_stall && ((mdu_like && !v.dn) || (run_like && v.st));
    redir = !mem_stall && !hold && run_like && v.br;
    bub   = !mem_stall && !hold && !redir && run_like && dep;
    exp_o = {!mem_stall && !hold && !bub, !mem_stall && !hold && !bub,
             !mem_stall && !hold, !mem_stall, !mem_stall,
             redir, redir || bub, hold};
    if (mem_stall) begin
      n_state = 2;
      n_ret = (m_state == 2) ? m_ret : m_state;
    end else begin
      n_ret = m_ret;
      if (mdu_like) n_state = v.dn ? 0 : 1;
      else n_state = v.st ? 1 : 0;
    end
    n_exp = (m_state != 0) && (m_wait == T - 1);
    if (n_exp) begin
      n_state = 0; n_ret = 0;
    end
  endtask

  task automatic drive(input in_t v);
    e_is_load = v.ld; e_rd = v.rd; d_rs1 = v.rs1; d_uses_rs1 = v.u1;
    d_rs2 = v.rs2; d_uses_rs2 = v.u2; e_branch_taken = v.br;
    e_mdu_start = v.st; mdu_done = v.dn; m_mem_req = v.rq; m_mem_ready = v.rdy;
  endtask

  task automatic sample_and_check(input string tag);
    last_o = {pc_enable, fd_enable, de_enable, em_enable, mw_enable,
              fd_flush, de_flush, em_flush};
    chk({tag, ".outs"}, {24'd0, last_o}, {24'd0, exp_o});
    chk({tag, ".err"}, {31'd0, hazard_err}, {31'd0, m_err});
`ifdef HAZARD_PERF_EN
    chk({tag, ".stall_cnt"}, stall_cycles, m_stall);
    chk({tag, ".flush_cnt"}, flush_events, m_flush);
`else
    chk({tag, ".stall_cnt"}, stall_cycles, 32'd0);
    chk({tag, ".flush_cnt"}, flush_events, 32'd0);
`endif
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic cyc(input in_t v, input string tag);
    drive(v);
    @(negedge clk);
    mdl_eval(v);
    sample_and_check(tag);
    if (!exp_o[7]) m_stall = m_stall + 32'd1;
    if (|exp_o[2:0]) m_flush = m_flush + 32'd1;
    if (n_exp) m_err = 1'b1;
    m_wait = (n_state != 0 && n_state == m_state) ? m_wait + 1 : 0;
    m_state = n_state;
    m_ret = n_ret;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse: outputs must immediately reflect the idle RUN state.
  task automatic do_reset(input in_t v);
    #2;
    reset = 1'b1;
    drive(v);
    mdl_reset();
    @(negedge clk);
    mdl_eval(v);
    sample_and_check("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t tbl[$];
  in_t idle, v;

  initial begin
    idle = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl.push_back('{mkin(1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0), O_LU,    "lu_rs1"});
    tbl.push_back('{mkin(1, 7, 1, 1, 7, 1, 0, 0, 0, 0, 0), O_LU,    "lu_rs2"});
    tbl.push_back('{mkin(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), O_DEF,   "lu_rd0"});
    tbl.push_back('{mkin(1, 5, 5, 0, 5, 0, 0, 0, 0, 0, 0), O_DEF,   "lu_unused"});
    tbl.push_back('{mkin(1, 5, 6, 1, 4, 1, 0, 0, 0, 0, 0), O_DEF,   "ld_nomatch"});
    tbl.push_back('{mkin(0, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0), O_DEF,   "noload"});
    tbl.push_back('{mkin(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), O_BR,    "branch"});
    tbl.push_back('{mkin(1, 5, 5, 1, 0, 0, 1, 0, 0, 0, 0), O_BR,    "branch_lu"});
    tbl.push_back('{mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_MDU,   "mdu_start"});
    tbl.push_back('{mkin(1, 5, 5, 1, 0, 0, 1, 1, 0, 0, 0), O_MDU,   "mdu_over_br"});
    tbl.push_back('{mkin(1, 5, 5, 1, 0, 0, 1, 1, 0, 1, 0), O_FREEZE, "ms_over_all"});
    tbl.push_back('{mkin(1, 5, 5, 1, 0, 0, 0, 0, 0, 1, 1), O_LU,    "mem_ready_lu"});

    drive(idle);
    @(posedge clk);
    #1;
    do_reset(idle);
    chk("reset.outs_default", {24'd0, last_o}, {24'd0, O_DEF});

    // Single-cycle hazard table, each from a fresh RUN state.
    foreach (tbl[k]) begin
      do_reset(idle);
      cyc(tbl[k].i, tbl[k].name);
      chk({"tbl.", tbl[k].name}, {24'd0, last_o}, {24'd0, tbl[k].exp});
    end

    // Load-use costs exactly one bubble: next cycle (load in MEM) is clean.
    do_reset(idle);
    cyc(mkin(1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0), "lu_seq0");
    chk("lu_seq.stall", {24'd0, last_o}, {24'd0, O_LU});
    cyc(mkin(0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0), "lu_seq1");
    chk("lu_seq.release", {24'd0, last_o}, {24'd0, O_DEF});

    // MDU op with done three cycles after start.
    do_reset(idle);
    for (int c = 0; c < 3; c++) begin
      cyc(mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "mdu_wait");
      chk("mdu.frozen", {24'd0, last_o}, {24'd0, O_MDU});
    end
    cyc(mkin(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "mdu_done");
    chk("mdu.done_cycle", {24'd0, last_o}, {24'd0, O_DEF});
    cyc(idle, "mdu_after");
    chk("mdu.after", {24'd0, last_o}, {24'd0, O_DEF});

    // Memory stall for two cycles in the middle of an MDU wait.
    do_reset(idle);
    cyc(mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "mdums0");
    cyc(mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "mdums1");
    for (int c = 0; c < 2; c++) begin
      cyc(mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), "mdums_mem");
      chk("mdums.freeze", {24'd0, last_o}, {24'd0, O_FREEZE});
    end
    cyc(mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1), "mdums_back");
    chk("mdums.back_to_mdu", {24'd0, last_o}, {24'd0, O_MDU});
    cyc(mkin(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), "mdums_done");
    chk("mdums.done", {24'd0, last_o}, {24'd0, O_DEF});
    chk("mdums.no_err", {31'd0, hazard_err}, 32'd0);

    // Watchdog: MDU never completes; forced release after T wait cycles.
    do_reset(idle);
    for (int c = 0; c < T + 1; c++)
      cyc(mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "wd_wait");
    chk("wd.held_before", {24'd0, last_o}, {24'd0, O_MDU});
    cyc(idle, "wd_release");
    chk("wd.release_outs", {24'd0, last_o}, {24'd0, O_DEF});
    chk("wd.err_set", {31'd0, hazard_err}, 32'd1);
    for (int c = 0; c < 3; c++) cyc(idle, "wd_sticky");
    chk("wd.err_sticky", {31'd0, hazard_err}, 32'd1);

    // Reset while parked in a memory wait.
    for (int c = 0; c < 3; c++) cyc(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "memwait");
    chk("memwait.freeze", {24'd0, last_o}, {24'd0, O_FREEZE});
    do_reset(idle);
    chk("rst_mid.outs", {24'd0, last_o}, {24'd0, O_DEF});
    chk("rst_mid.err", {31'd0, hazard_err}, 32'd0);
    chk("rst_mid.stall_cnt", stall_cycles, 32'd0);
    cyc(mkin(1, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0), "rst_mid_after");
    chk("rst_mid.run_rules", {24'd0, last_o}, {24'd0, O_LU});

    // Random traffic against the model.
    do_reset(idle);
    for (int n = 0; n < 3000; n++) begin
      v.ld  = $urandom_range(0, 1);
      v.rd  = 5'($urandom_range(0, 3));
      v.rs1 = 5'($urandom_range(0, 3));
      v.rs2 = 5'($urandom_range(0, 3));
      v.u1  = $urandom_range(0, 1);
      v.u2  = $urandom_range(0, 1);
      v.br  = ($urandom_range(0, 7) == 0);
      v.st  = ($urandom_range(0, 3) == 0);
      v.dn  = $urandom_range(0, 1);
      v.rq  = ($urandom_range(0, 3) == 0);
      v.rdy = $urandom_range(0, 1);
      if ($urandom_range(0, 199) == 0) do_reset(v);
      else cyc(v, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
